uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter data_width, default 8, meaning number of data bits per frame.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 5208, meaning clock cycles per serial bit (50 MHz / 9600).
REQ-003 The block SHALL have parameter PARITY_EN, default 0, meaning 1 inserts one even-parity bit after the data bits.
REQ-004 The block SHALL have parameter STOP_BITS, default 1, meaning number of stop bits; legal values are 1 and 2.
REQ-005 The block SHALL have port clk  input  1  system clock; all state changes occur on the rising edge.
REQ-006 The block SHALL have port rst  input  1  reset; one clock domain, asynchronous, active-high.
REQ-007 The block SHALL have port tx_start  input  1  request to send data_in.
REQ-008 The block SHALL have port data_in  input  data_width  byte to transmit.
REQ-009 The block SHALL have port tx_ready  output  1  high when a new request is accepted.
REQ-010 The block SHALL have port data_bit  output  1  serial line, idle high, driven directly from a flop.
REQ-011 The block SHALL have port busy  output  1  high while a frame is in progress, including the DONE cycle.
REQ-012 The block SHALL have port done  output  1  one-cycle pulse after the last stop bit completes.

Function
REQ-013 The FSM SHALL use states IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT and DONE.
REQ-014 In IDLE: tx_ready=1, busy=0, data_bit=1.
REQ-015 A handshake SHALL occur on a rising edge where tx_start=1 and tx_ready=1; on that edge data_in is latched into a shift register and the FSM enters START_BIT.
REQ-016 tx_start SHALL be ignored while tx_ready=0; the latched data SHALL not change mid-frame even if data_in changes.
REQ-017 data_bit SHALL go low on the clock edge after the handshake (one-cycle latency).
REQ-018 Each serial bit SHALL be held for exactly CLKS_PER_BIT cycles, timed by a clk_counter of width $clog2(CLKS_PER_BIT) that counts 0..CLKS_PER_BIT-1 and resets to 0 on each bit boundary.
REQ-019 START_BIT SHALL drive 0 for one bit time, then enter DATA_BITS.
REQ-020 DATA_BITS SHALL send data_width bits LSB first, using bit_counter 0..data_width-1.
- After bit data_width-1, the FSM SHALL go to PARITY_BIT if PARITY_EN=1, else to STOP_BIT.
REQ-021 PARITY_BIT SHALL drive the XOR of the latched data bits (even parity) for one bit time.
REQ-022 STOP_BIT SHALL drive 1 for STOP_BITS bit times, then enter DONE.
REQ-023 DONE SHALL last exactly one cycle with done=1, data_bit=1, tx_ready=0, then return to IDLE.
REQ-024 Total frame length, from handshake edge to the done pulse, SHALL be (1+data_width+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles; done is asserted in the cycle that follows.
REQ-025 Back-to-back: tx_start held high SHALL be accepted in the first IDLE cycle after DONE, so the line has at least one extra idle-high cycle between frames.
REQ-026 Any unreachable state encoding SHALL return the FSM to IDLE on the next edge with data_bit=1.

Reset
REQ-027 While rst=1, asynchronously: FSM=IDLE, data_bit=1, tx_ready=1, busy=0, done=0, counters=0, shift register=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately, with no partial stop bit and no done pulse.
REQ-029 After rst deasserts, the first handshake SHALL be accepted on the first rising edge.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-030 Basic frame: send 0xA5 -> data_bit sequence per 4 cycles is 0,1,0,1,0,0,1,0,1,1; done pulses 40 cycles after the handshake edge.
REQ-031 Parity: PARITY_EN=1, send 0x07 -> parity bit 1; send 0xA5 -> parity bit 0; frame length is 44 cycles.
REQ-032 Busy ignore: pulse tx_start with 0x3C mid-frame of 0xA5 -> only 0xA5 is transmitted, and tx_ready stays 0 until after done.
REQ-033 Back-to-back plus loopback: hold tx_start, send 0x55 then 0xAA with data_bit driving a matching receiver -> the receiver reports 0x55 then 0xAA, and the gap between frames is at least one idle cycle.
REQ-034 Reset mid-frame: assert rst during bit 3 of 0xFF -> data_bit=1 and tx_ready=1 immediately, with no done pulse; a following send of 0x81 transmits correctly.
REQ-035 STOP_BITS=2: send 0x00 -> the line stays high for 8 cycles before done, and the frame length is 44 cycles.

Source files
------------

// File: rtl/uart_tx_if.sv
// uart_tx_if: request/serial-line bundle between a UART transmitter and its client
//   tx_start  client -> uart   request to send data_in
//   data_in   client -> uart   word to transmit (data_width bits)
//   tx_ready  uart -> client   high when a request is accepted (idle)
//   data_bit  uart -> line     serial output, idle high
//   busy      uart -> client   high while a frame is in progress
//   done      uart -> client   one-cycle pulse after the last stop bit
interface uart_tx_if #(
    parameter int data_width = 8
);
    logic                  tx_start;
    logic [data_width-1:0] data_in;
    logic                  tx_ready;
    logic                  data_bit;
    logic                  busy;
    logic                  done;

    modport master (
        output tx_start, data_in,
        input  tx_ready, data_bit, busy, done
    );

    modport slave (
        input  tx_start, data_in,
        output tx_ready, data_bit, busy, done
    );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: serial transmitter, start bit + LSB-first data + optional even parity + 1/2 stop bits
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset
//   bus   uart_tx_if.slave: tx_start/data_in in, tx_ready/data_bit/busy/done out
module uart_tx #(
    parameter int data_width   = 8,
    parameter int CLKS_PER_BIT = 5208,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input logic       clk,
    input logic       rst,
    uart_tx_if.slave  bus
);
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = data_width > 1 ? $clog2(data_width) : 1;

    typedef enum logic [2:0] {
        IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT, DONE
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [CW-1:0]         r_clk_cnt, w_clk_cnt_nxt, w_clk_cnt_inc;
    logic [BW-1:0]         r_bit_cnt, w_bit_cnt_nxt;
    logic                  r_stop_cnt, w_stop_cnt_nxt;
    logic [data_width-1:0] r_shift, w_shift_nxt;
    logic                  r_parity, w_parity_nxt;
    logic                  r_data_bit, w_data_bit_nxt;
    logic                  w_bit_end;

    assign w_bit_end     = r_clk_cnt == CW'(CLKS_PER_BIT - 1);
    assign w_clk_cnt_inc = w_bit_end ? '0 : r_clk_cnt + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_clk_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_data_bit <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_clk_cnt  <= w_clk_cnt_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_parity   <= w_parity_nxt;
            r_data_bit <= w_data_bit_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clk_cnt_nxt  = '0;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_stop_cnt_nxt = r_stop_cnt;
        w_shift_nxt    = r_shift;
        w_parity_nxt   = r_parity;
        case (r_state)
            IDLE: begin
                if (bus.tx_start) begin
                    w_state_nxt    = START_BIT;
                    w_shift_nxt    = bus.data_in;
                    // parity is captured at latch time because the shifter is consumed
                    w_parity_nxt   = ^bus.data_in;
                    w_bit_cnt_nxt  = '0;
                    w_stop_cnt_nxt = 1'b0;
                end
            end
            START_BIT: begin
                w_clk_cnt_nxt = w_clk_cnt_inc;
                if (w_bit_end) w_state_nxt = DATA_BITS;
            end
            DATA_BITS: begin
                w_clk_cnt_nxt = w_clk_cnt_inc;
                if (w_bit_end) begin
                    if (r_bit_cnt == BW'(data_width - 1)) begin
                        w_state_nxt = (PARITY_EN != 0) ? PARITY_BIT : STOP_BIT;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + BW'(1);
                        w_shift_nxt   = r_shift >> 1;
                    end
                end
            end
            PARITY_BIT: begin
                w_clk_cnt_nxt = w_clk_cnt_inc;
                if (w_bit_end) w_state_nxt = STOP_BIT;
            end
            STOP_BIT: begin
                w_clk_cnt_nxt = w_clk_cnt_inc;
                if (w_bit_end) begin
                    if (r_stop_cnt == 1'(STOP_BITS - 1)) w_state_nxt = DONE;
                    else w_stop_cnt_nxt = 1'b1;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        // line level is registered from the next state so it changes together with the FSM
        w_data_bit_nxt = (w_state_nxt == START_BIT)  ? 1'b0 :
                         (w_state_nxt == DATA_BITS)  ? w_shift_nxt[0] :
                         (w_state_nxt == PARITY_BIT) ? w_parity_nxt : 1'b1;
    end

    assign bus.tx_ready = r_state == IDLE;
    assign bus.busy     = r_state != IDLE;
    assign bus.done     = r_state == DONE;
    assign bus.data_bit = r_data_bit;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed + random frames on three uart_tx configurations against a frame model
module tb_uart_tx;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       r_start [3];
    logic [7:0] r_din   [3];
    logic       w_bit   [3];
    logic       w_ready [3];
    logic       w_busy  [3];
    logic       w_done  [3];

    int n_checks = 0;
    int n_errors = 0;

    logic       rx_en = 1'b0;
    logic [7:0] rx_b;
    logic [7:0] rx_q [$];

    uart_tx_if #(.data_width(8)) if0 ();
    uart_tx_if #(.data_width(8)) if1 ();
    uart_tx_if #(.data_width(8)) if2 ();

    assign if0.tx_start = r_start[0];
    assign if0.data_in  = r_din[0];
    assign if1.tx_start = r_start[1];
    assign if1.data_in  = r_din[1];
    assign if2.tx_start = r_start[2];
    assign if2.data_in  = r_din[2];

    assign w_bit[0] = if0.data_bit;
    assign w_bit[1] = if1.data_bit;
    assign w_bit[2] = if2.data_bit;
    assign w_ready[0] = if0.tx_ready;
    assign w_ready[1] = if1.tx_ready;
    assign w_ready[2] = if2.tx_ready;
    assign w_busy[0] = if0.busy;
    assign w_busy[1] = if1.busy;
    assign w_busy[2] = if2.busy;
    assign w_done[0] = if0.done;
    assign w_done[1] = if1.done;
    assign w_done[2] = if2.done;

    uart_tx #(.data_width(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .bus(if0)
    );
    uart_tx #(.data_width(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .bus(if1)
    );
    uart_tx #(.data_width(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .bus(if2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // line level of bit slot idx of a frame: start, data LSB first, optional parity, then stop
    function automatic logic exp_bit(input logic [7:0] d, input int par, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (par != 0 && idx == 9) return ^d;
        return 1'b1;
    endfunction

    // one frame on instance k; inj >= 0 pulses tx_start with 0x3C in that cycle; hold keeps tx_start high
    task automatic send(input int k, input logic [7:0] d, input int par, input int stops,
                        input int inj, input bit hold);
        int total;
        total = (1 + 8 + par + stops) * CPB;
        @(negedge clk);
        r_start[k] = 1'b1;
        r_din[k]   = d;
        chk($sformatf("u%0d ready_before_%02h", k, d), w_ready[k], 1);
        chk($sformatf("u%0d idle_line_before_%02h", k, d), w_bit[k], 1);
        @(posedge clk);
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            if (c == inj) begin
                r_start[k] = 1'b1;
                r_din[k]   = 8'h3C;
            end else if (c == inj + 1 || c == 0) begin
                r_start[k] = hold;
            end
            chk($sformatf("u%0d line_%02h_c%0d", k, d, c), w_bit[k], exp_bit(d, par, c / CPB));
            chk($sformatf("u%0d ready_%02h_c%0d", k, d, c), w_ready[k], 0);
            chk($sformatf("u%0d busy_%02h_c%0d", k, d, c), w_busy[k], 1);
            chk($sformatf("u%0d done_%02h_c%0d", k, d, c), w_done[k], 0);
        end
        @(negedge clk);
        chk($sformatf("u%0d done_pulse_%02h", k, d), w_done[k], 1);
        chk($sformatf("u%0d done_line_%02h", k, d), w_bit[k], 1);
        chk($sformatf("u%0d done_ready_%02h", k, d), w_ready[k], 0);
        chk($sformatf("u%0d done_busy_%02h", k, d), w_busy[k], 1);
    endtask

    // loopback receiver on instance 0: sample mid-bit after a start edge
    always begin
        @(negedge clk);
        if (rx_en && w_bit[0] === 1'b0) begin
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                rx_b[i] = w_bit[0];
            end
            repeat (CPB) @(negedge clk);
            if (w_bit[0] === 1'b1) rx_q.push_back(rx_b);
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            r_start[i] = 1'b0;
            r_din[i]   = 8'h00;
        end
        #1 rst = 1'b1;
        #2;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d reset_ready", i), w_ready[i], 1);
            chk($sformatf("u%0d reset_line", i), w_bit[i], 1);
            chk($sformatf("u%0d reset_busy", i), w_busy[i], 0);
            chk($sformatf("u%0d reset_done", i), w_done[i], 0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;

        send(0, 8'hA5, 0, 1, -1, 1'b0);
        send(1, 8'h07, 1, 1, -1, 1'b0);
        send(1, 8'hA5, 1, 1, -1, 1'b0);

        send(0, 8'hA5, 0, 1, 13, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("u0 ignored_line_%0d", i), w_bit[0], 1);
            chk($sformatf("u0 ignored_busy_%0d", i), w_busy[0], 0);
        end

        send(2, 8'h00, 0, 2, -1, 1'b0);

        for (int n = 0; n < 3; n++) begin
            send(0, 8'($urandom), 0, 1, -1, 1'b0);
            send(1, 8'($urandom), 1, 1, -1, 1'b0);
            send(2, 8'($urandom), 0, 2, -1, 1'b0);
        end

        @(negedge clk);
        r_start[0] = 1'b1;
        r_din[0]   = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        r_start[0] = 1'b0;
        repeat (17) @(negedge clk);
        chk("u0 pre_abort_busy", w_busy[0], 1);
        rst = 1'b1;
        #1;
        chk("u0 abort_line", w_bit[0], 1);
        chk("u0 abort_ready", w_ready[0], 1);
        chk("u0 abort_busy", w_busy[0], 0);
        chk("u0 abort_done", w_done[0], 0);
        @(negedge clk);
        rst = 1'b0;
        send(0, 8'h81, 0, 1, -1, 1'b0);

        rx_q.delete();
        rx_en = 1'b1;
        send(0, 8'h55, 0, 1, -1, 1'b1);
        send(0, 8'hAA, 0, 1, -1, 1'b0);
        repeat (4) @(negedge clk);
        rx_en = 1'b0;
        chk("loop_count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            chk("loop_first", rx_q[0], 8'h55);
            chk("loop_second", rx_q[1], 8'hAA);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
